// File: rtl/mult_control_unit.sv
// ---------------------------------------------------------------------------
// mult_control_unit
//   Sequencer for a shift-add signed multiplier datapath. Issues one INIT cycle,
//   then WIDTH ADD/SHIFT pairs, subtracting on the final ADD so the sign bit of
//   a two's-complement multiplier is weighted negatively. Holds the result until
//   start is released. Contains no arithmetic; it only drives datapath strobes.
//
// State table:
//   state | meaning
//   IDLE  | waiting; clear pulses clear_ax, start launches a multiply
//   INIT  | clear A/X, load B from Switches, zero the iteration counter
//   ADD   | write adder result into A/X (add or subtract Switches when m=1)
//   SHIFT | arithmetic right shift of {X,A,B}; advance or finish
//   HOLD  | product valid (done); wait for start to drop
//
// Ports:
//   Clk, Reset_n        clock (rising edge) and async active-low reset
//   start, clear        level requests from the operator
//   m                   multiplier LSB, B[0], from the datapath
//   clear_ax, load_b    INIT / idle-clear strobes
//   ld_a, add_en, sub   adder write-back controls
//   shift_en            {X,A,B} shift strobe
//   busy, done          status
//   count               iteration index 0..WIDTH-1
// ---------------------------------------------------------------------------
module mult_control_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          clear,
    input  logic          m,
    output logic          clear_ax,
    output logic          load_b,
    output logic          ld_a,
    output logic          add_en,
    output logic          sub,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_iter;

    assign last_iter = (count_q == LAST);
    assign count     = count_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        clear_ax = 1'b0;
        load_b   = 1'b0;
        ld_a     = 1'b0;
        add_en   = 1'b0;
        sub      = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // clear takes priority over start; gated by reset so every
                // output is low while Reset_n is asserted.
                if (clear) begin
                    clear_ax = Reset_n;
                end else if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                clear_ax = 1'b1;
                load_b   = 1'b1;
                busy     = 1'b1;
                count_d  = '0;
                state_d  = S_ADD;
            end
            S_ADD: begin
                ld_a    = 1'b1;
                busy    = 1'b1;
                add_en  = m;
                // The MSB of a two's-complement multiplier has negative weight.
                sub     = m & last_iter;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                if (last_iter) begin
                    state_d = S_HOLD;
                end else begin
                    count_d = count_q + CW'(1);
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_control_unit
//   Drives the sequencer against a behavioural model of the shift-add datapath
//   and compares the resulting 64-bit product with a plain signed multiply.
// ---------------------------------------------------------------------------
module tb_mult_control_unit;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH);
    localparam int LAT   = 2 + 2 * WIDTH;

    logic          Clk;
    logic          Reset_n;
    logic          start;
    logic          clear;
    logic          m;
    logic          clear_ax, load_b, ld_a, add_en, sub, shift_en, busy, done;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    mult_control_unit #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .clear    (clear),
        .m        (m),
        .clear_ax (clear_ax),
        .load_b   (load_b),
        .ld_a     (ld_a),
        .add_en   (add_en),
        .sub      (sub),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural datapath: 33-bit adder, X flop, A and B registers.
    logic [31:0]        sw;
    logic               x_q;
    logic [31:0]        a_q, b_q;
    logic signed [32:0] addend, sum;

    assign m = b_q[0];

    always_comb begin
        addend = '0;
        if (add_en) addend = sub ? -$signed({sw[31], sw}) : $signed({sw[31], sw});
        sum = $signed({x_q, a_q}) + addend;
    end

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (clear_ax) begin
                x_q <= 1'b0;
                a_q <= '0;
            end
            if (load_b) b_q <= sw;
            if (ld_a) begin
                a_q <= sum[31:0];
                if (add_en) x_q <= sum[32];
            end
            if (shift_en) begin
                a_q <= {x_q, a_q[31:1]};
                b_q <= {a_q[0], b_q[31:1]};
            end
        end
    end

    // Per-cycle observation of strobes.
    int          sub_cnt, init_cnt, clr_cnt;
    logic [31:0] add_mask;

    always @(negedge Clk) begin
        if (Reset_n) begin
            checks++;
            if (ld_a && shift_en) begin
                errors++;
                $display("FAIL strobe_overlap: ld_a=%0b shift_en=%0b, required not both", ld_a, shift_en);
            end
            checks++;
            if (sub && !add_en) begin
                errors++;
                $display("FAIL sub_without_add: sub=%0b add_en=%0b", sub, add_en);
            end
            if (sub) sub_cnt++;
            if (load_b) init_cnt++;
            if (clear_ax) clr_cnt++;
            if (ld_a && add_en) add_mask[count] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one multiply; returns the cycle at which done was first seen,
    // counted from the cycle start was raised.
    task automatic do_mult(input logic [31:0] mcand, input logic [31:0] mplier,
                           input bit hold_start, input bit clr_during, output int lat);
        @(posedge Clk); #1;
        sw = mplier; start = 1'b1; clear = 1'b0; lat = 0;
        sub_cnt = 0; add_mask = '0;
        @(posedge Clk); #1; lat = 1;
        @(posedge Clk); #1; lat = 2;
        sw = mcand;
        if (!hold_start) start = 1'b0;
        if (clr_during) begin
            clear = 1'b1;
            clr_cnt = 0;
        end
        while (!done && lat < 200) begin
            @(posedge Clk); #1; lat++;
        end
        clear = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] mcand;
        logic [31:0] mplier;
        logic [63:0] prod;
        int          subs;
        logic [31:0] mask;
    } vec_t;

    task automatic run_vec(input vec_t v, input bit hold_start, input bit clr_during);
        int lat;
        do_mult(v.mcand, v.mplier, hold_start, clr_during, lat);
        check({v.name, "_latency"}, 64'(lat), 64'(LAT));
        check({v.name, "_product"}, {a_q, b_q}, v.prod);
        check({v.name, "_sub_count"}, 64'(sub_cnt), 64'(v.subs));
        check({v.name, "_add_mask"}, 64'(add_mask), 64'(v.mask));
        if (clr_during) check({v.name, "_clear_masked"}, 64'(clr_cnt), 64'd0);
    endtask

    function automatic vec_t make_vec(input string name, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        v.name = name; v.mcand = a; v.mplier = b;
        v.prod = 64'(pa * pb);
        v.subs = int'(b[31]);
        v.mask = b;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        logic [63:0] held;
        int n, lat, init_before;

        vecs[0] = '{"pos_pos", 32'd7, 32'd3, 64'd21, 0, 32'h0000_0003};
        vecs[1] = '{"pos_neg", 32'd7, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD, 1, 32'hFFFF_FFFB};
        vecs[2] = '{"neg_neg", 32'hFFFF_FFFA, 32'hFFFF_FFFC, 64'd24, 1, 32'hFFFF_FFFC};
        vecs[3] = '{"max_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1, 32'h8000_0000};
        vecs[4] = '{"min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, 32'h8000_0000};

        sub_cnt = 0; init_cnt = 0; clr_cnt = 0; add_mask = '0;
        Reset_n = 1'b0; start = 1'b0; clear = 1'b0; sw = '0;
        #12;
        check("reset_outputs", 64'({clear_ax, load_b, ld_a, add_en, sub, shift_en, busy, done}), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        #11 Reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            if (i % 4 == 1) ra = -32'($urandom_range(1, 100));
            v = make_vec($sformatf("rand%0d", i), ra, rb);
            run_vec(v, 1'b0, (i % 2) == 1);
        end

        // Asynchronous reset in the middle of an operation.
        @(posedge Clk); #1;
        sw = 32'h1234_5677; start = 1'b1; n = 0;
        while (!(ld_a && count == CW'(5)) && n < 100) begin
            @(posedge Clk); #1; n++;
        end
        check("midrun_reached_add5", 64'(n < 100), 64'd1);
        start = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        check("midrun_reset_outputs", 64'({clear_ax, load_b, ld_a, add_en, sub, shift_en, busy, done}), 64'd0);
        check("midrun_reset_count", 64'(count), 64'd0);
        @(posedge Clk); #3 Reset_n = 1'b1;
        run_vec(make_vec("after_reset", 32'd1000, 32'hFFFF_FF9C), 1'b0, 1'b0);

        // Start held through completion; clear in HOLD is ignored.
        run_vec(make_vec("held_start", 32'hFFFF_FFF9, 32'd9), 1'b1, 1'b0);
        held = {a_q, b_q};
        init_before = init_cnt;
        clr_cnt = 0;
        clear = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            if (done) n++;
        end
        clear = 1'b0;
        check("hold_done_stays", 64'(n), 64'd4);
        check("hold_no_retrigger", 64'(init_cnt - init_before), 64'd0);
        check("hold_clear_masked", 64'(clr_cnt), 64'd0);
        check("hold_product_kept", {a_q, b_q}, held);
        start = 1'b0;
        @(posedge Clk); #1;
        check("release_to_idle", 64'({busy, done}), 64'd0);
        start = 1'b1; sw = 32'd5;
        @(posedge Clk); #1;
        check("reraise_init", 64'({load_b, busy}), 64'b11);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge Clk); #1; n++;
        end
        check("reraise_completes", 64'(n < 200), 64'd1);

        // start and clear together in IDLE: clear wins.
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        start = 1'b1; clear = 1'b1;
        #2;
        check("idle_clear_pulse", 64'(clear_ax), 64'd1);
        @(posedge Clk); #1;
        check("idle_clear_no_init", 64'({load_b, busy}), 64'd0);
        start = 1'b0; clear = 1'b0;
        @(posedge Clk); #1;
        check("idle_quiet", 64'({clear_ax, busy, done}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_control_unit.md
Name: mult_control_unit

Overview:
- Sequencing FSM for the shift-add signed multiplier datapath: 33-bit adder (A + Switches, subtract mode, X sign flop), A register, B register and the right-shifting {X,A,B} chain.
- Runs WIDTH add/shift iterations on a start handshake and subtracts on the final iteration for two's-complement multipliers.
- Drives every datapath strobe; owns no arithmetic itself.

Parameters:
- WIDTH, 32, operand width and iteration count (legal ≥ 2).
- CW, $clog2(WIDTH), iteration counter width.

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  level request to begin a multiply (Run)
- clear  in  1  level request to clear A and X while idle
- m  in  1  current multiplier LSB (B[0]) from the datapath
- clear_ax  out  1  clear A register and X flop this cycle
- load_b  out  1  load B from Switches this cycle
- ld_a  out  1  write adder S into A and adder x into X this cycle
- add_en  out  1  adder outputEnable (add Switches); 0 means add zero, X holds
- sub  out  1  adder subtract select
- shift_en  out  1  arithmetic right shift of {X,A,B} this cycle
- busy  out  1  multiply in progress
- done  out  1  product valid in {A,B}
- count  out  CW  iteration index, 0..WIDTH-1

Behaviour:
- States: IDLE, INIT, ADD, SHIFT, HOLD. Registered state, counter and outputs are Moore-decoded from state/count, except add_en/sub, which combine state with m.
- Reset (Reset_n=0, asynchronous, also mid-operation): state=IDLE, count=0. All outputs 0, including busy and done.
- IDLE:
  - clear=1 → clear_ax=1 that cycle; state stays IDLE.
  - clear=0 and start=1 → INIT.
  - clear=1 and start=1 together → clear wins and start is ignored that cycle.
- INIT (1 cycle): clear_ax=1, load_b=1, busy=1, count←0 → ADD.
- ADD (1 cycle): ld_a=1, busy=1, add_en=m, sub = m & (count==WIDTH-1) → SHIFT.
- SHIFT (1 cycle): shift_en=1, busy=1.
  - count==WIDTH-1 → HOLD, count unchanged.
  - Otherwise count←count+1 → ADD.
- HOLD: done=1, busy=0, no strobes; waits for start=0, then → IDLE.
  - start held high does not retrigger.
  - clear is ignored in HOLD so the product is preserved.
- Latency: done first high 2+2·WIDTH cycles after the cycle start is sampled in IDLE (66 for WIDTH=32).
- Invariants:
  - ld_a and shift_en never both high.
  - sub=1 only when add_en=1.
  - Exactly one sub-capable ADD per operation.
  - start and clear are ignored in INIT/ADD/SHIFT.
- count never wraps; it is max WIDTH-1.

Test Plan:
- Reset mid-run: assert Reset_n=0 in ADD with count=5 → immediately state IDLE, all outputs 0, count=0; after release, start runs a fresh 66-cycle operation.
- Unsigned-pattern multiply with a behavioural datapath model: Switches=7, B=3, pulse start → add_en high only in ADD cycles for count 0,1; sub never high; done at cycle 66; {A,B}=21.
- Negative multiplier: Switches=7, B=-5 (0xFFFFFFFB) → sub=1 exactly once, at count=31; product {A,B}=-35 (64-bit two's complement).
- Both operands negative: Switches=-6, B=-4 → product 24; X and A sign-extend correctly through every shift.
- Handshake: hold start high through completion → done stays high, no second INIT. Drop start → IDLE in the next cycle. Re-raise start → new INIT.
- Clear priority and masking:
  - start=1 and clear=1 together in IDLE → clear_ax pulses, no INIT.
  - clear=1 during SHIFT and during HOLD → no clear_ax; the product is unchanged.
